// File: rtl/counter_udm_m.sv
// Up/down counter with a programmable upper limit, synchronous load with clamp,
// wrap or saturate behaviour at the boundaries, a one-cycle terminal-count pulse
// and a sticky overflow/underflow flag.
module counter_udm_m #(
  parameter int unsigned WIDTH    = 5,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] One  = WIDTH'(1);
  localparam logic [WIDTH-1:0] Zero = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic             at_top;     // count_q at or above the current limit
  logic             at_bottom;  // count_q is zero
  logic [WIDTH-1:0] load_val;   // data clamped into 0..limit
  logic             boundary;   // enabled, non-load edge at a boundary

  // Boundary detection and load clamp, all against the limit sampled this edge.
  always_comb begin
    at_top    = (count_q >= limit);
    at_bottom = (count_q == Zero);
    load_val  = (data <= limit) ? data : limit;
    boundary  = !load && enable && (up_dn ? at_top : at_bottom);
  end

  // Next-state selection: load beats enable beats hold.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    // A boundary event in the same edge overrides the clear.
    ovf_d   = (ovf_q && !clr_ovf) || boundary;

    if (load) begin
      count_d = load_val;
    end else if (enable) begin
      if (up_dn) begin
        if (at_top) begin
          count_d = SATURATE ? limit : Zero;
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (at_bottom) begin
          count_d = SATURATE ? Zero : limit;
        end else begin
          // Also taken when count_q sits above a freshly lowered limit.
          count_d = count_q - One;
        end
      end
      tc_d = boundary;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= Zero;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    count = count_q;
    tc    = tc_q;
    ovf   = ovf_q;
  end

endmodule

// File: tb/tb_counter_udm_m.sv
// Directed bench for counter_udm_m: one wrapping and one saturating instance
// share the same stimulus; each task checks the instance(s) it targets.
module tb_counter_udm_m;

  localparam int unsigned W = 5;

  logic         clk;
  logic         rst_;
  logic         load;
  logic [W-1:0] data;
  logic         enable;
  logic         up_dn;
  logic [W-1:0] limit;
  logic         clr_ovf;

  logic [W-1:0] count0, count1;
  logic         tc0, tc1, ovf0, ovf1;

  int n_cmp;
  int n_fail;

  counter_udm_m #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk     (clk),
    .rst_    (rst_),
    .load    (load),
    .data    (data),
    .enable  (enable),
    .up_dn   (up_dn),
    .limit   (limit),
    .clr_ovf (clr_ovf),
    .count   (count0),
    .tc      (tc0),
    .ovf     (ovf0)
  );

  counter_udm_m #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk     (clk),
    .rst_    (rst_),
    .load    (load),
    .data    (data),
    .enable  (enable),
    .up_dn   (up_dn),
    .limit   (limit),
    .clr_ovf (clr_ovf),
    .count   (count1),
    .tc      (tc1),
    .ovf     (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_    = 1'b0;
    load    = 1'b0;
    enable  = 1'b0;
    up_dn   = 1'b1;
    clr_ovf = 1'b0;
    data    = 'x;
    limit   = 'x;
    #2;
    n_cmp++;
    if (count0 !== 5'd0 || tc0 !== 1'b0 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial count=%0d tc=%b ovf=%b want 0/0/0", count0, tc0, ovf0);
    end
    #1 rst_ = 1'b1;
    step();
    // Hold with X on data/limit must keep outputs known.
    n_cmp++;
    if (count0 !== 5'd0 || tc0 !== 1'b0 || ovf0 !== 1'b0 ||
        count1 !== 5'd0 || tc1 !== 1'b0 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_x count=%0d/%0d tc=%b/%b ovf=%b/%b want all 0",
               count0, count1, tc0, tc1, ovf0, ovf1);
    end
  endtask

  task automatic test_wrap_up();
    logic [W-1:0] exp_c [4];
    logic         exp_t [4];
    exp_c[0] = 5'd29; exp_c[1] = 5'd30; exp_c[2] = 5'd31; exp_c[3] = 5'd0;
    exp_t[0] = 1'b0;  exp_t[1] = 1'b0;  exp_t[2] = 1'b0;  exp_t[3] = 1'b1;
    limit = 5'd31;
    data  = 5'd29;
    load  = 1'b1;
    step();
    load   = 1'b0;
    enable = 1'b1;
    up_dn  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (count0 !== exp_c[i] || tc0 !== exp_t[i] || ovf0 !== exp_t[i]) begin
        n_fail++;
        $display("FAIL wrap_up[%0d] count=%0d tc=%b ovf=%b want %0d/%b/%b",
                 i, count0, tc0, ovf0, exp_c[i], exp_t[i], exp_t[i]);
      end
      if (i < 3) step();
    end
    enable = 1'b0;
    step();
    n_cmp++;
    if (count0 !== 5'd0 || tc0 !== 1'b0 || ovf0 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_up_hold count=%0d tc=%b ovf=%b want 0/0/1", count0, tc0, ovf0);
    end
  endtask

  task automatic test_wrap_down();
    clr_ovf = 1'b1;
    limit   = 5'd9;
    data    = 5'd0;
    load    = 1'b1;
    step();
    clr_ovf = 1'b0;
    load    = 1'b0;
    n_cmp++;
    if (count0 !== 5'd0 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL down_setup count=%0d ovf=%b want 0/0", count0, ovf0);
    end
    enable = 1'b1;
    up_dn  = 1'b0;
    step();
    enable = 1'b0;
    n_cmp++;
    if (count0 !== 5'd9 || tc0 !== 1'b1 || ovf0 !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap count=%0d tc=%b ovf=%b want 9/1/1", count0, tc0, ovf0);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_cmp++;
    if (count0 !== 5'd9 || tc0 !== 1'b0 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL down_clr count=%0d tc=%b ovf=%b want 9/0/0", count0, tc0, ovf0);
    end
    enable = 1'b1;
    step();
    n_cmp++;
    if (count0 !== 5'd8 || tc0 !== 1'b0 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL down_dec count=%0d tc=%b ovf=%b want 8/0/0", count0, tc0, ovf0);
    end
    enable = 1'b0;
    data   = 5'd0;
    load   = 1'b1;
    step();
    load    = 1'b0;
    enable  = 1'b1;
    clr_ovf = 1'b1;
    step();
    enable  = 1'b0;
    clr_ovf = 1'b0;
    n_cmp++;
    if (count0 !== 5'd9 || tc0 !== 1'b1 || ovf0 !== 1'b1) begin
      n_fail++;
      $display("FAIL down_set_wins count=%0d tc=%b ovf=%b want 9/1/1", count0, tc0, ovf0);
    end
  endtask

  task automatic test_saturate();
    logic [W-1:0] exp_c [4];
    logic         exp_t [4];
    exp_c[0] = 5'd20; exp_c[1] = 5'd20; exp_c[2] = 5'd20; exp_c[3] = 5'd20;
    exp_t[0] = 1'b0;  exp_t[1] = 1'b1;  exp_t[2] = 1'b1;  exp_t[3] = 1'b1;
    clr_ovf = 1'b1;
    limit   = 5'd20;
    data    = 5'd19;
    load    = 1'b1;
    step();
    clr_ovf = 1'b0;
    load    = 1'b0;
    n_cmp++;
    if (count1 !== 5'd19 || tc1 !== 1'b0 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_load count=%0d tc=%b ovf=%b want 19/0/0", count1, tc1, ovf1);
    end
    enable = 1'b1;
    up_dn  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (count1 !== exp_c[i] || tc1 !== exp_t[i] || ovf1 !== exp_t[i]) begin
        n_fail++;
        $display("FAIL sat_up[%0d] count=%0d tc=%b ovf=%b want %0d/%b/%b",
                 i, count1, tc1, ovf1, exp_c[i], exp_t[i], exp_t[i]);
      end
    end
    enable = 1'b0;
    data   = 5'd0;
    load   = 1'b1;
    step();
    load   = 1'b0;
    enable = 1'b1;
    up_dn  = 1'b0;
    step();
    enable = 1'b0;
    n_cmp++;
    if (count1 !== 5'd0 || tc1 !== 1'b1 || ovf1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_down count=%0d tc=%b ovf=%b want 0/1/1", count1, tc1, ovf1);
    end
  endtask

  task automatic test_clamp_limit();
    clr_ovf = 1'b1;
    limit   = 5'd20;
    data    = 5'd25;
    load    = 1'b1;
    enable  = 1'b1;
    up_dn   = 1'b1;
    step();
    clr_ovf = 1'b0;
    load    = 1'b0;
    n_cmp++;
    if (count0 !== 5'd20 || tc0 !== 1'b0 || ovf0 !== 1'b0 || count1 !== 5'd20 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_load count=%0d/%0d tc=%b/%b ovf=%b want 20/20 0/0 0",
               count0, count1, tc0, tc1, ovf0);
    end
    limit = 5'd15;
    up_dn = 1'b0;
    step();
    n_cmp++;
    if (count0 !== 5'd19 || tc0 !== 1'b0 || count1 !== 5'd19) begin
      n_fail++;
      $display("FAIL above_limit_dec1 count=%0d/%0d tc=%b want 19/19 0", count0, count1, tc0);
    end
    step();
    n_cmp++;
    if (count0 !== 5'd18 || count1 !== 5'd18) begin
      n_fail++;
      $display("FAIL above_limit_dec2 count=%0d/%0d want 18/18", count0, count1);
    end
    up_dn = 1'b1;
    step();
    enable = 1'b0;
    n_cmp++;
    if (count0 !== 5'd0 || tc0 !== 1'b1 || ovf0 !== 1'b1 ||
        count1 !== 5'd15 || tc1 !== 1'b1) begin
      n_fail++;
      $display("FAIL above_limit_up count=%0d/%0d tc=%b/%b ovf=%b want 0/15 1/1 1",
               count0, count1, tc0, tc1, ovf0);
    end
  endtask

  task automatic test_limit_zero();
    limit  = 5'd0;
    enable = 1'b1;
    up_dn  = 1'b1;
    step();
    n_cmp++;
    if (count0 !== 5'd0 || tc0 !== 1'b1 || count1 !== 5'd0 || tc1 !== 1'b1) begin
      n_fail++;
      $display("FAIL lim0_up count=%0d/%0d tc=%b/%b want 0/0 1/1", count0, count1, tc0, tc1);
    end
    up_dn = 1'b0;
    step();
    n_cmp++;
    if (count0 !== 5'd0 || tc0 !== 1'b1 || count1 !== 5'd0 || tc1 !== 1'b1) begin
      n_fail++;
      $display("FAIL lim0_down count=%0d/%0d tc=%b/%b want 0/0 1/1", count0, count1, tc0, tc1);
    end
    enable = 1'b0;
    step();
    n_cmp++;
    if (count0 !== 5'd0 || tc0 !== 1'b0 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL lim0_hold count=%0d tc=%b/%b want 0 0/0", count0, tc0, tc1);
    end
  endtask

  task automatic test_reset_mid();
    limit  = 5'd31;
    data   = 5'd0;
    load   = 1'b1;
    step();
    load   = 1'b0;
    enable = 1'b1;
    up_dn  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (count0 !== 5'(i)) begin
        n_fail++;
        $display("FAIL mid_count[%0d] count=%0d want %0d", i, count0, i);
      end
    end
    #2 rst_ = 1'b0;
    #1;
    n_cmp++;
    if (count0 !== 5'd0 || tc0 !== 1'b0 || ovf0 !== 1'b0 || count1 !== 5'd0 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset count=%0d/%0d tc=%b ovf=%b/%b want 0/0 0 0/0",
               count0, count1, tc0, ovf0, ovf1);
    end
    #1 rst_ = 1'b1;
    step();
    n_cmp++;
    if (count0 !== 5'd1 || tc0 !== 1'b0) begin
      n_fail++;
      $display("FAIL resume1 count=%0d tc=%b want 1/0", count0, tc0);
    end
    step();
    enable = 1'b0;
    n_cmp++;
    if (count0 !== 5'd2 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL resume2 count=%0d ovf=%b want 2/0", count0, ovf0);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_clamp_limit();
    test_limit_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_udm_m.md
COUNTER_UDM_M -- requirements
Module: counter_udm_m

Interface
REQ-001 SHALL have parameter WIDTH, default 5, count/data/limit bit width (WIDTH >= 2).
REQ-002 SHALL have parameter SATURATE, default 0, boundary mode (0 = wrap, 1 = hold at boundary).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load  input  1  synchronous load of data.
REQ-006 SHALL have port data  input  WIDTH  load value.
REQ-007 SHALL have port enable  input  1  count enable.
REQ-008 SHALL have port up_dn  input  1  direction (1 = up, 0 = down).
REQ-009 SHALL have port limit  input  WIDTH  upper count bound; legal range is 0..limit.
REQ-010 SHALL have port clr_ovf  input  1  synchronous clear of sticky ovf.
REQ-011 SHALL have port count  output  WIDTH  registered count value.
REQ-012 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-013 SHALL have port ovf  output  1  registered sticky overflow/underflow flag.

Function
REQ-014 Per-edge priority SHALL be: load > enable > hold.
REQ-015 Load SHALL set count = data if data <= limit, else count = limit (clamp); load SHALL drive tc = 0 next cycle and leave ovf unchanged (except by clr_ovf).
REQ-016 With load = 0 and enable = 0, count SHALL hold and tc SHALL be 0 next cycle.
REQ-017 Up count, count < limit: count SHALL become count + 1.
REQ-018 Up count, count >= limit (boundary): count SHALL become 0 (SATURATE = 0) or limit (SATURATE = 1).
REQ-019 Down count, count > 0: count SHALL become count - 1 (also when count > limit after a limit change).
REQ-020 Down count, count == 0 (boundary): count SHALL become limit (SATURATE = 0) or stay 0 (SATURATE = 1).
REQ-021 Every enabled, non-load edge at a boundary (REQ-018/REQ-020) SHALL set tc = 1 for the following cycle only, and SHALL set ovf = 1; in saturate mode this recurs on each held boundary edge.
REQ-022 clr_ovf SHALL clear ovf at the next edge; simultaneous boundary event and clr_ovf SHALL leave ovf = 1 (set wins).
REQ-023 limit = 0 SHALL make every enabled edge a boundary event; count SHALL stay 0.
REQ-024 limit SHALL be sampled each edge; a change takes effect on the next edge with no pipeline delay.
REQ-025 Arithmetic SHALL be modulo 2**WIDTH internally, with no intermediate overflow; count never exceeds 2**WIDTH - 1.
REQ-026 Count latency SHALL be one clock from load/enable sampled to count update.

Reset
REQ-027 rst_ = 0 SHALL immediately, without a clock, force count = 0, tc = 0, ovf = 0.
REQ-028 Reset asserted mid-count SHALL abort the operation; the first edge after rst_ release SHALL act on the inputs sampled at that edge.
REQ-029 All outputs SHALL be known (no X) after reset, regardless of X on data/limit while load = 0.

Verification (WIDTH = 5)
REQ-030 Assert rst_ = 0 between edges -> count = 0, tc = 0, ovf = 0 before the next clk rise.
REQ-031 SATURATE = 0, limit = 31, load data = 29, then enable up for 3 edges -> count 29, 30, 31, 0; tc = 1 only in the cycle after 31->0; ovf = 1 thereafter.
REQ-032 SATURATE = 0, limit = 9, count = 0, enable down -> count 9, tc pulse, ovf = 1; pulse clr_ovf -> ovf = 0; clr_ovf coincident with next wrap -> ovf stays 1.
REQ-033 SATURATE = 1, limit = 20, load 19, enable up for 4 edges -> count 20, 20, 20, 20; tc = 1 on edges 2-4; ovf = 1.
REQ-034 limit = 20, load = 1 with data = 25 and enable = 1 -> count = 20 (clamped, load wins), tc = 0; then lower limit to 15 and count down -> 19, 18, ...; count up from 20 -> boundary event.
REQ-035 Count up from 0 to 4, assert rst_ mid-cycle, release -> count = 0 immediately; counting resumes 1, 2 on the following enabled edges.
